hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/hazard_track.sv | 30 +++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states and the
// shadow-tracker record carried alongside EX, MEM and WB.
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             reg_wr;
        logic             is_load;
    } track_t;

    localparam track_t TRACK_BUBBLE = '0;

    // A tracker can supply an operand only if it writes a real register (x0 never forwards).
    function automatic logic src_match(track_t t, logic [REG_W-1:0] rs, logic use_rs);
        return use_rs && t.reg_wr && (t.rd != '0) && (t.rd == rs);
    endfunction

    function automatic fwd_sel_e fwd_pick(track_t ex_t, track_t mem_t,
                                          logic [REG_W-1:0] rs, logic use_rs);
        if (src_match(ex_t, rs, use_rs)) begin
            return FWD_MEM;
        end else if (src_match(mem_t, rs, use_rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_track.sv
// One shadow pipeline-stage register: holds on freeze, loads a bubble on flush/stall,
// otherwise captures the record of the instruction entering the stage.
module hazard_track
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   bubble,
    input  track_t din,
    output track_t dout
);

    track_t stage_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q <= TRACK_BUBBLE;
        end else if (hold) begin
            stage_q <= stage_q;
        end else if (bubble) begin
            stage_q <= TRACK_BUBBLE;
        end else begin
            stage_q <= din;
        end
    end

    assign dout = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: registered forwarding selects plus combinational stall/flush
// control, with a memory-wait FSM and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_reg_wr,
    input  logic             id_is_load,
    input  logic             ex_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             stall_mem,
    output logic [15:0]      stall_cnt
);

    track_t    id_trk, ex_trk, mem_trk, wb_trk;
    hz_state_e state_q;
    fwd_sel_e  fwd_a_q, fwd_b_q;
    logic      mem_wait, br_flush, load_use, ex_bubble;
    logic      ex_hit_rs1, ex_hit_rs2;
    logic [15:0] cnt_q;

    assign id_trk = '{rd: id_rd, reg_wr: id_reg_wr, is_load: id_is_load};

    assign ex_hit_rs1 = id_use_rs1 && (id_rs1 == ex_trk.rd);
    assign ex_hit_rs2 = id_use_rs2 && (id_rs2 == ex_trk.rd);

    // Priority: memory wait > branch flush > load-use; everything is silent in reset.
    always_comb begin
        mem_wait  = rst && dmem_req && !dmem_ready;
        br_flush  = rst && !mem_wait && ex_br_taken;
        load_use  = rst && !mem_wait && !br_flush && ex_trk.is_load && (ex_trk.rd != '0)
                    && (ex_hit_rs1 || ex_hit_rs2);
        ex_bubble = br_flush || load_use;
    end

    assign stall_if  = mem_wait || load_use;
    assign stall_id  = mem_wait || load_use;
    assign stall_mem = mem_wait;
    assign flush_id  = br_flush;
    assign flush_ex  = br_flush || load_use;

    hazard_track u_track_ex (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_wait),
        .bubble (ex_bubble),
        .din    (id_trk),
        .dout   (ex_trk)
    );

    hazard_track u_track_mem (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_wait),
        .bubble (1'b0),
        .din    (ex_trk),
        .dout   (mem_trk)
    );

    hazard_track u_track_wb (
        .clk    (clk),
        .rst    (rst),
        .hold   (mem_wait),
        .bubble (1'b0),
        .din    (mem_trk),
        .dout   (wb_trk)
    );

    // WB shadow completes the pipeline picture but no decision depends on it yet.
    logic unused_wb;
    assign unused_wb = ^wb_trk;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:      if (mem_wait) state_q <= MEM_WAIT;
                MEM_WAIT: if (dmem_ready) state_q <= RUN;
                default:  state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            if (!mem_wait) begin
                fwd_a_q <= ex_bubble ? FWD_RF : fwd_pick(ex_trk, mem_trk, id_rs1, id_use_rs1);
                fwd_b_q <= ex_bubble ? FWD_RF : fwd_pick(ex_trk, mem_trk, id_rs2, id_use_rs2);
            end
            if (stall_id && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios and random traffic, all
// compared each cycle against a pipeline-occupancy model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_wr, id_is_load;
    logic        ex_br_taken, dmem_req, dmem_ready;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall_if, stall_id, flush_id, flush_ex, stall_mem;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_reg_wr   (id_reg_wr),
        .id_is_load  (id_is_load),
        .ex_br_taken (ex_br_taken),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .stall_mem   (stall_mem),
        .stall_cnt   (stall_cnt)
    );

    // Model: the instructions occupying EX, MEM, WB (index 0, 1, 2).
    typedef struct { int rd; int wr; int ld; } slot_t;
    slot_t pipe [3];
    int m_fa, m_fb, m_cnt, m_state;
    int e_mw, e_br, e_lu;
    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int produces(int k, int rs, int used);
        return (used != 0 && rs != 0 && pipe[k].wr != 0 && pipe[k].rd == rs) ? 1 : 0;
    endfunction

    function automatic int pick(int rs, int used);
        if (produces(0, rs, used) != 0) return 1;
        if (produces(1, rs, used) != 0) return 2;
        return 0;
    endfunction

    task automatic model_eval();
        int r, dep;
        r     = pipe[0].rd;
        dep   = ((id_use_rs1 && int'(id_rs1) == r) || (id_use_rs2 && int'(id_rs2) == r)) ? 1 : 0;
        e_mw  = (rst && dmem_req && !dmem_ready) ? 1 : 0;
        e_br  = (rst && e_mw == 0 && ex_br_taken) ? 1 : 0;
        e_lu  = (rst && e_mw == 0 && e_br == 0 && pipe[0].ld != 0 && r != 0 && dep != 0) ? 1 : 0;
    endtask

    task automatic model_update();
        int fa, fb, bub;
        model_eval();
        if (rst == 1'b0) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{rd: 0, wr: 0, ld: 0};
            m_fa = 0; m_fb = 0; m_cnt = 0; m_state = 0;
        end else begin
            if ((e_mw | e_lu) != 0) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (m_state == 0 && e_mw != 0) m_state = 1;
            else if (m_state == 1 && dmem_ready) m_state = 0;
            if (e_mw == 0) begin
                fa  = pick(int'(id_rs1), int'(id_use_rs1));
                fb  = pick(int'(id_rs2), int'(id_use_rs2));
                bub = e_br | e_lu;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (bub != 0) pipe[0] = '{rd: 0, wr: 0, ld: 0};
                else pipe[0] = '{rd: int'(id_rd), wr: int'(id_reg_wr), ld: int'(id_is_load)};
                m_fa = (bub != 0) ? 0 : fa;
                m_fb = (bub != 0) ? 0 : fb;
            end
        end
    endtask

    task automatic compare_all();
        model_eval();
        chk("stall_if",  int'(stall_if),  e_mw | e_lu);
        chk("stall_id",  int'(stall_id),  e_mw | e_lu);
        chk("stall_mem", int'(stall_mem), e_mw);
        chk("flush_id",  int'(flush_id),  e_br);
        chk("flush_ex",  int'(flush_ex),  e_br | e_lu);
        chk("fwd_a",     int'(fwd_a),     m_fa);
        chk("fwd_b",     int'(fwd_b),     m_fb);
        chk("stall_cnt", int'(stall_cnt), m_cnt);
        chk("state",     int'(dut.state_q), m_state);
    endtask

    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic instr(int rs1, int u1, int rs2, int u2, int rd, int wr, int ld);
        id_rs1 = 5'(rs1); id_use_rs1 = 1'(u1);
        id_rs2 = 5'(rs2); id_use_rs2 = 1'(u2);
        id_rd  = 5'(rd);  id_reg_wr  = 1'(wr); id_is_load = 1'(ld);
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0; ex_br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        nop();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ex_br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        nop();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("reset_fwd_a", int'(fwd_a), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        chk("reset_stall_id", int'(stall_id), 0);

        // ALU-ALU forwarding: back-to-back then with one gap instruction.
        do_reset();
        instr(1, 1, 2, 1, 5, 1, 0); step();
        instr(5, 1, 3, 1, 8, 1, 0); step();
        chk("alu_fwd_mem", int'(fwd_a), 1);
        instr(1, 1, 2, 1, 6, 1, 0); step();
        nop(); step();
        instr(6, 1, 0, 0, 9, 1, 0); step();
        chk("alu_fwd_wb", int'(fwd_a), 2);

        // Load-use: one stall bubble, then the loaded value comes from WB.
        do_reset();
        instr(1, 1, 0, 0, 7, 1, 1); step();
        instr(4, 1, 7, 1, 10, 1, 0);
        #1;
        chk("lu_stall_id", int'(stall_id), 1);
        chk("lu_flush_ex", int'(flush_ex), 1);
        chk("lu_flush_id", int'(flush_id), 0);
        step();
        chk("lu_bubble_fwd", int'(fwd_b), 0);
        #1;
        chk("lu_single_cycle", int'(stall_id), 0);
        step();
        chk("lu_fwd_b", int'(fwd_b), 2);
        chk("lu_cnt", int'(stall_cnt), 1);

        // x0 producer (even a load) never forwards or stalls.
        do_reset();
        instr(0, 0, 0, 0, 0, 1, 1); step();
        instr(0, 1, 0, 1, 11, 1, 0);
        #1;
        chk("x0_no_stall", int'(stall_id), 0);
        step();
        chk("x0_fwd_a", int'(fwd_a), 0);

        // Memory wait of three cycles freezes forwarding.
        do_reset();
        instr(0, 0, 0, 0, 5, 1, 0); step();
        instr(5, 1, 0, 0, 12, 1, 0); step();
        nop();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stall_mem", int'(stall_mem), 1);
            chk("mw_stall_if", int'(stall_if), 1);
            step();
            chk("mw_fwd_frozen", int'(fwd_a), 1);
            chk("mw_state", int'(dut.state_q), 1);
        end
        dmem_ready = 1'b1;
        #1;
        chk("mw_release", int'(stall_mem), 0);
        step();
        chk("mw_state_run", int'(dut.state_q), 0);
        chk("mw_cnt", int'(stall_cnt), 3);
        dmem_req = 1'b0; dmem_ready = 1'b0;

        // Branch held during a memory wait flushes once, when the wait ends.
        do_reset();
        instr(3, 1, 0, 0, 4, 1, 0);
        ex_br_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bw_no_flush_id", int'(flush_id), 0);
            chk("bw_no_flush_ex", int'(flush_ex), 0);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        chk("bw_flush_id", int'(flush_id), 1);
        chk("bw_flush_ex", int'(flush_ex), 1);
        step();
        ex_br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("bw_flush_once", int'(flush_id), 0);
        step();

        // Reset in the middle of a memory wait.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step(); step();
        chk("rw_in_wait", int'(dut.state_q), 1);
        rst = 1'b0;
        #1;
        chk("rw_stall_gated", int'(stall_id), 0);
        chk("rw_stall_mem_gated", int'(stall_mem), 0);
        step();
        rst = 1'b1; dmem_req = 1'b0;
        chk("rw_state_run", int'(dut.state_q), 0);
        chk("rw_cnt", int'(stall_cnt), 0);
        #1;
        chk("rw_no_residual", int'(stall_if), 0);
        step();

        // Branch coinciding with load-use: flush only.
        do_reset();
        instr(1, 1, 0, 0, 7, 1, 1); step();
        instr(7, 1, 0, 0, 2, 1, 0); ex_br_taken = 1'b1;
        #1;
        chk("brlu_no_stall", int'(stall_id), 0);
        chk("brlu_flush_id", int'(flush_id), 1);
        step();
        ex_br_taken = 1'b0;

        // Counter saturation over a very long memory wait.
        do_reset();
        nop();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 65540; i++) step();
        chk("sat_cnt", int'(stall_cnt), 65535);
        dmem_ready = 1'b1;
        step();
        dmem_req = 1'b0; dmem_ready = 1'b0;

        // Random traffic with small register range to provoke hazards.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int wr, ld;
            rst = ($urandom_range(0, 99) != 0);
            wr  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            ld  = (wr != 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
            instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), wr, ld);
            ex_br_taken = ($urandom_range(0, 9) == 0);
            dmem_req    = ($urandom_range(0, 3) == 0);
            dmem_ready  = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
